// File: rtl/max7219_spi_tx.sv
// rtl/max7219_spi_tx.sv - MAX7219 daisy-chain frame serializer (MSB first, LOAD pulse after last bit)
module max7219_spi_tx #(
  parameter int DIVIDER = 22,
  parameter int CHAIN   = 1,
  parameter int CS_HOLD = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [16*CHAIN-1:0]   cmd_data_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mosi_o,
  output logic                  sclk_o,
  output logic                  sel_o
);
  localparam int N     = 16 * CHAIN;
  localparam int BIT_W = $clog2(N + 1);
  localparam int DIV_W = (DIVIDER > 0) ? $clog2(DIVIDER + 1) : 1;
  localparam int GAP_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIVIDER);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(N - 1);
  localparam logic [GAP_W-1:0] LAST_GAP   = GAP_W'(CS_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       sr_q, sr_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               sel_q, sel_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               done_q, done_d;
  logic               tick;

  assign tick = (state_q != S_IDLE) && (div_q == '0);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    div_d   = div_q;
    gap_d   = gap_q;
    sel_d   = sel_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      div_d = tick ? DIV_RELOAD : div_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          sr_d    = cmd_data_i;
          mosi_d  = cmd_data_i[N-1];
          sel_d   = 1'b0;
          sclk_d  = 1'b0;
          bit_d   = '0;
          div_d   = DIV_RELOAD;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Data only moves on falling edges so the slave sees it stable on every rise.
            sclk_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              mosi_d  = 1'b0;
              state_d = S_LATCH;
            end else begin
              sr_d   = sr_q << 1;
              mosi_d = sr_d[N-1];
              bit_d  = bit_q + 1'b1;
            end
          end
        end
      end
      S_LATCH: begin
        if (tick) begin
          sel_d   = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == LAST_GAP) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: begin
        sel_d   = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= DIV_RELOAD;
      gap_q   <= '0;
      sel_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign mosi_o      = mosi_q;
  assign sclk_o      = sclk_q;
  assign sel_o       = sel_q;
endmodule
